// File: rtl/audio_pkg.sv
// audio_pkg: shared audio widths, I2S slot geometry, FIFO sizing and a slot bit-selection helper.
package audio_pkg;
   localparam int SAMPLE_W   = 18;
   localparam int SLOT_BITS  = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int BIT_W      = $clog2(SLOT_BITS);
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
   typedef logic [SAMPLE_W-1:0] sample_t;
   typedef logic [BIT_W-1:0]    bit_idx_t;
   // Serial position b (1..SAMPLE_W) carries d[SAMPLE_W-b], MSB first; every other position is zero.
   function automatic logic slot_bit(sample_t d, bit_idx_t b);
      bit_idx_t idx;
      idx = BIT_W'(SAMPLE_W) - b;
      return (b != '0 && b <= BIT_W'(SAMPLE_W)) ? d[idx] : 1'b0;
   endfunction
endpackage

// File: rtl/i2s_speaker_tx_if.sv
// i2s_speaker_tx_if: sample stream into the I2S transmitter.
//   sample_in/sample_valid/sample_ready: valid/ready sample handshake
//   mute: zero the serial data while keeping the FIFO running
//   level: current FIFO occupancy
interface i2s_speaker_tx_if;
   import audio_pkg::*;
   sample_t            sample_in;
   logic               sample_valid;
   logic               sample_ready;
   logic               mute;
   logic [CNT_W-1:0]   level;
   modport master (output sample_in, sample_valid, mute, input sample_ready, level);
   modport slave  (input sample_in, sample_valid, mute, output sample_ready, level);
endinterface

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: small synchronous sample FIFO with a combinational head.
//   clk, reset (sync, active-low), push/wdata, pop/head, count, full, empty
module i2s_tx_fifo
   import audio_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  sample_t          wdata,
   input  logic             pop,
   output sample_t          head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(FIFO_DEPTH);
   sample_t       mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;
   assign head    = mem[rd_ptr];
   assign full    = count == CNT_W'(FIFO_DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end
endmodule

// File: rtl/i2s_speaker_tx.sv
// i2s_speaker_tx: I2S transmitter for an 18-bit speaker DAC/amplifier, fed from a 4-entry sample FIFO.
//   clk, reset (sync, active-low)
//   s: sample stream interface (sample_in/valid/ready, mute, level)
//   BCLK: clk/2 bit clock, LRCLK: word select (0 = left), DIN: serial data
//   underrun: one-cycle pulse when a slot load finds the FIFO empty
//   Build option I2S_TX_STEREO_EN: a second FIFO entry feeds the right slot; otherwise the left sample is repeated.
module i2s_speaker_tx
   import audio_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   i2s_speaker_tx_if.slave s,
   output logic            BCLK,
   output logic            LRCLK,
   output logic            DIN,
   output logic            underrun
);
   logic     run, fall, wrap, nxt_lr, start, push, pop, full, empty;
   bit_idx_t bit_cnt, nb;
   sample_t  head, hold_l, slot_data;
   assign fall = BCLK;
   assign wrap = bit_cnt == BIT_W'(SLOT_BITS - 1);
   assign nxt_lr = LRCLK ^ wrap;
   assign nb = bit_cnt + BIT_W'(1);
   assign push = s.sample_valid && s.sample_ready;
   assign pop = start && !empty;
   // run holds ready low until the first cycle after reset release.
   assign s.sample_ready = run && !full;
`ifdef I2S_TX_STEREO_EN
   sample_t hold_r;
   assign start = fall && wrap;
   assign slot_data = nxt_lr ? hold_r : hold_l;
`else
   assign start = fall && wrap && LRCLK;
   assign slot_data = hold_l;
`endif
   i2s_tx_fifo u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (s.sample_in),
      .pop   (pop),
      .head  (head),
      .count (s.level),
      .full  (full),
      .empty (empty)
   );
   // Slot position 0 always carries a zero, so a holding register loaded on that same
   // falling event is already valid when its MSB goes out one BCLK later.
   always_ff @(posedge clk) begin
      if (!reset) begin
         run      <= 1'b0;
         BCLK     <= 1'b0;
         LRCLK    <= 1'b1;
         bit_cnt  <= BIT_W'(SLOT_BITS - 1);
         DIN      <= 1'b0;
         underrun <= 1'b0;
         hold_l   <= '0;
`ifdef I2S_TX_STEREO_EN
         hold_r   <= '0;
`endif
      end else begin
         run      <= 1'b1;
         BCLK     <= !BCLK;
         underrun <= start && empty;
         if (fall) begin
            bit_cnt <= nb;
            LRCLK   <= nxt_lr;
            DIN     <= !s.mute && slot_bit(slot_data, nb);
         end
         if (start && !nxt_lr) hold_l <= empty ? '0 : head;
`ifdef I2S_TX_STEREO_EN
         if (start && nxt_lr) hold_r <= empty ? '0 : head;
`endif
      end
   end
endmodule

// File: tb/tb_i2s_speaker_tx.sv
// tb_i2s_speaker_tx: randomized and directed checks of i2s_speaker_tx against a frame-arithmetic model.
module tb_i2s_speaker_tx;
   import audio_pkg::*;
`ifdef I2S_TX_STEREO_EN
   localparam bit STEREO = 1'b1;
`else
   localparam bit STEREO = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic BCLK, LRCLK, DIN, underrun;
   i2s_speaker_tx_if bus();
   i2s_speaker_tx dut (
      .clk      (clk),
      .reset    (reset),
      .s        (bus),
      .BCLK     (BCLK),
      .LRCLK    (LRCLK),
      .DIN      (DIN),
      .underrun (underrun)
   );
   always #5 clk = ~clk;
   int compared = 0;
   int mismatched = 0;
   // Model: n = clk edges since release; falling event f = n/2 sits at slot bit (f-1)%32 of slot ((f-1)/32)%2.
   sample_t q[$];
   sample_t m_hl, m_hr;
   int      n, m_b, m_slot;
   bit      m_run, m_lr, m_din, m_und, accepted;
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask
   task automatic step();
      bit      rs, v, mt, rdy, empty;
      int      f;
      sample_t d, data;
      rs = reset;
      v = bus.sample_valid;
      mt = bus.mute;
      d = bus.sample_in;
      rdy = m_run && q.size() < FIFO_DEPTH;
      @(posedge clk);
      accepted = 0;
      m_und = 0;
      if (!rs) begin
         q.delete();
         m_hl = '0;
         m_hr = '0;
         n = 0;
         m_run = 0;
         m_lr = 1;
         m_din = 0;
         m_b = 31;
         m_slot = 1;
      end else begin
         m_run = 1;
         n++;
         empty = q.size() == 0;
         if (n % 2 == 0) begin
            f = n / 2;
            m_b = (f - 1) % SLOT_BITS;
            m_slot = ((f - 1) / SLOT_BITS) % 2;
            m_lr = m_slot[0];
            if (m_b == 0 && (m_slot == 0 || STEREO)) begin
               m_und = empty;
               if (m_slot == 0) m_hl = empty ? '0 : q.pop_front();
               else m_hr = empty ? '0 : q.pop_front();
            end
            data = (m_slot == 1 && STEREO) ? m_hr : m_hl;
            m_din = (!mt && m_b >= 1 && m_b <= SAMPLE_W) ? data[SAMPLE_W - m_b] : 1'b0;
         end
         if (v && rdy) begin
            q.push_back(d);
            accepted = 1;
         end
      end
      #1;
      chk("BCLK", BCLK, n % 2);
      chk("LRCLK", LRCLK, m_lr);
      chk("DIN", DIN, m_din);
      chk("underrun", underrun, m_und);
      chk("sample_ready", bus.sample_ready, m_run && q.size() < FIFO_DEPTH);
      chk("level", bus.level, q.size());
   endtask
   task automatic run_cycles(int k);
      for (int i = 0; i < k; i++) step();
   endtask
   task automatic push_one(sample_t d);
      int k;
      k = 0;
      bus.sample_in = d;
      bus.sample_valid = 1'b1;
      do begin
         step();
         k++;
      end while (!accepted && k < 300);
      chk("push_timeout", accepted, 1);
      bus.sample_valid = 1'b0;
   endtask
   task automatic wait_pos(int slot, int b);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!(m_slot == slot && m_b == b) && k < 400);
      chk("wait_pos_timeout", m_slot == slot && m_b == b, 1);
   endtask
   initial begin
      int und, acc;
      bus.sample_in = '0;
      bus.sample_valid = 1'b0;
      bus.mute = 1'b0;
      run_cycles(3);
      reset = 1'b1;
      push_one(18'h2AAAA);
      run_cycles(300);
      for (int i = 0; i < 800; i++) begin
         bus.sample_valid = $urandom_range(0, 39) == 0;
         bus.sample_in = sample_t'($urandom);
         if ($urandom_range(0, 199) == 0) bus.mute = !bus.mute;
         step();
      end
      bus.sample_valid = 1'b0;
      bus.mute = 1'b1;
      push_one(18'h3FFFF);
      run_cycles(300);
      bus.mute = 1'b0;
      run_cycles(640);
      und = 0;
      for (int i = 0; i < 384; i++) begin
         step();
         if (underrun) und++;
      end
      chk("underrun_rate", und, STEREO ? 6 : 3);
      wait_pos(1, 3);
      push_one(sample_t'($urandom));
      push_one(sample_t'($urandom));
      push_one(sample_t'($urandom));
      wait_pos(1, 10);
      reset = 1'b0;
      run_cycles(2);
      reset = 1'b1;
      wait_pos(0, 5);
      acc = 0;
      bus.sample_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.sample_in = sample_t'($urandom);
         if (bus.sample_ready) acc++;
         step();
      end
      chk("accepts_until_full", acc, FIFO_DEPTH);
      for (int i = 0; i < 140; i++) begin
         bus.sample_in = sample_t'($urandom);
         step();
      end
      bus.sample_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         bus.sample_valid = $urandom_range(0, 29) == 0;
         bus.sample_in = sample_t'($urandom);
         step();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/i2s_speaker_tx.md
I2S_SPEAKER_TX -- requirements
Module: i2s_speaker_tx

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all logic on posedge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: sample_in  input  18  two's-complement audio sample.
REQ-004 SHALL have port: sample_valid  input  1  sample_in offered this cycle.
REQ-005 SHALL have port: sample_ready  output  1  block accepts sample this cycle.
REQ-006 SHALL have port: mute  input  1  force zero data on DIN.
REQ-007 SHALL have port: BCLK  output  1  registered bit clock, clk/2.
REQ-008 SHALL have port: LRCLK  output  1  word select; low = left slot, high = right slot.
REQ-009 SHALL have port: DIN  output  1  serial data to DAC/amplifier.
REQ-010 SHALL have port: underrun  output  1  one-cycle pulse when a frame starts with no sample available.

Function
REQ-011 SHALL toggle BCLK every clk cycle while out of reset; a "falling event" is a cycle where BCLK goes 1->0.
REQ-012 SHALL keep slot counter bit_cnt 0..31, advancing only on falling events; 31 wraps to 0.
REQ-013 SHALL toggle LRCLK on the falling event where bit_cnt wraps 31->0.
REQ-014 SHALL drive DIN on falling events: bit_cnt = b in 1..18 -> data[18-b] (MSB one BCLK after LRCLK edge); b = 0 or 19..31 -> 0.
REQ-015 SHALL buffer samples in a 4-entry FIFO; transfer occurs when sample_valid && sample_ready; sample_ready = (count < 4), registered-count based.
REQ-016 SHALL pop one FIFO entry into the left holding register on the falling event where LRCLK goes 1->0 (frame start).
REQ-017 SHALL, in mono mode, transmit the left holding register in both slots of the frame.
REQ-018 SHALL, at frame start with FIFO empty, load 18'h0 and pulse underrun for exactly one clk cycle.
REQ-019 SHALL keep count unchanged on simultaneous push and pop; SHALL never accept while count = 4.
REQ-020 SHALL, while mute = 1, drive DIN = 0 but still pop samples and report underrun normally; mute is sampled per bit.

Reset
REQ-021 SHALL, while reset = 0: BCLK = 0, LRCLK = 1, bit_cnt = 31, DIN = 0, FIFO empty, holding registers = 0, underrun = 0, sample_ready = 0.
REQ-022 SHALL make sample_ready = 1 in the first cycle after release; first falling event occurs on the second clk cycle after release and starts a left slot.
REQ-023 SHALL discard all FIFO contents and any partial frame when reset is asserted mid-frame.

Configuration
REQ-024 SHALL, with I2S_TX_STEREO_EN defined, pop a second FIFO entry into a right holding register at the LRCLK 0->1 falling event and transmit it in the right slot; an empty FIFO there loads 0 and pulses underrun.
REQ-025 SHALL, without I2S_TX_STEREO_EN, behave in mono mode per REQ-017.

Structure
REQ-026 SHALL place SAMPLE_W = 18, SLOT_BITS = 32, FIFO_DEPTH = 4 in shared package audio_pkg.
REQ-027 SHALL implement the buffer as sub-module i2s_tx_fifo (push/pop/count/full/empty).

Verification
REQ-028 Push 18'h2AAAA after reset -> left slot DIN, sampled on BCLK rising edges at bit_cnt 1..18, = 1,0,1,0,...,1,0; right slot identical; remainder 0.
REQ-029 Hold sample_valid = 1 with no frame boundary -> 4 accepts, then sample_ready = 0; after next frame start, ready = 1 for one accept.
REQ-030 No pushes -> underrun pulses once per frame (every 128 clk), DIN stays 0.
REQ-031 Push 18'h3FFFF with mute = 1 -> DIN all 0, FIFO count decrements at frame start.
REQ-032 Assert reset at bit_cnt = 10 of a right slot with 3 entries queued -> all outputs at REQ-021 values, FIFO empty, first post-reset frame underruns.
REQ-033 I2S_TX_STEREO_EN defined, push 18'h00001 then 18'h20000 -> left slot LSB bit (bit_cnt 18) = 1, right slot MSB bit (bit_cnt 1) = 1, all other bits 0.
